icache_set_assoc: RTL and testbench

Parametrised set-associative instruction cache with an integrated miss-handling FSM. It sits between the Instruction Unit and the memory controller. It serves 32-bit instruction fetches on a hit. On a miss it issues a block refill request with a ready/valid handshake, then installs the returned block using per-set round-robin replacement. A flush input invalidates the whole cache for fence.i.

---
 rtl/icache_set_assoc.sv | 227 ++++++++++++++++++++++
 tb/tb_icache_set_assoc.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_set_assoc.sv
// rtl/icache_set_assoc.sv - set-associative instruction cache with refill FSM
//
// Purpose:
//   Serves 32-bit instruction fetches from a WAYS-way, SETS-set cache. A hit
//   returns the word one cycle later. A miss issues one block refill request
//   (ready/valid). The returned block is installed in the lowest-numbered
//   invalid way, or else in the way named by the per-set round-robin victim
//   pointer. flushIn invalidates every line. A flush while a refill is
//   outstanding poisons that refill, so its block is written back as invalid.
//
// Ports:
//   clkIn         in   system clock
//   resetIn       in   asynchronous active-high reset
//   flushIn       in   invalidate all lines (one-cycle pulse)
//   instrInValid  in   fetch request valid, held with address until served
//   instrAddrIn   in   word-aligned fetch address
//   instrOutValid out  one-cycle pulse, instruction delivered
//   instrOut      out  instruction word
//   instrAddrOut  out  address of instrOut
//   memReqValid   out  refill request valid
//   memReqAddr    out  block address of refill
//   memReqReady   in   memory accepts request
//   memDataValid  in   refill block valid (one-cycle pulse)
//   memDataIn     in   refill block, word 0 in bits [31:0]

module icache_set_assoc #(
  parameter int BLOCK_WIDTH = 4,
  parameter int INDEX_WIDTH = 4,
  parameter int WAY_WIDTH   = 1
) (
  input  logic                          clkIn,
  input  logic                          resetIn,
  input  logic                          flushIn,
  input  logic                          instrInValid,
  input  logic [31:0]                   instrAddrIn,
  output logic                          instrOutValid,
  output logic [31:0]                   instrOut,
  output logic [31:0]                   instrAddrOut,
  output logic                          memReqValid,
  output logic [32-BLOCK_WIDTH-1:0]     memReqAddr,
  input  logic                          memReqReady,
  input  logic                          memDataValid,
  input  logic [(2**BLOCK_WIDTH)*8-1:0] memDataIn
);

  localparam int TAG_WIDTH  = 32 - BLOCK_WIDTH - INDEX_WIDTH;
  localparam int BLOCK_SIZE = 2 ** BLOCK_WIDTH;
  localparam int DATA_W     = BLOCK_SIZE * 8;
  localparam int SETS       = 2 ** INDEX_WIDTH;
  localparam int WAYS       = 2 ** WAY_WIDTH;
  localparam int VW         = (WAY_WIDTH > 0) ? WAY_WIDTH : 1;
  localparam int BA_W       = 32 - BLOCK_WIDTH;
  // Bit offset of the addressed word inside a block; the low five bits are
  // masked so a misaligned address still selects a whole word.
  localparam logic [BLOCK_WIDTH+2:0] BITOFF_MASK = ~((BLOCK_WIDTH+3)'(31));

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic                   r_valid [SETS][WAYS];
  logic [TAG_WIDTH-1:0]   r_tag   [SETS][WAYS];
  logic [DATA_W-1:0]      r_data  [SETS][WAYS];

  logic [BA_W-1:0]        r_blk_addr;
  logic                   r_poison;
  logic                   r_out_valid;
  logic [31:0]            r_instr;
  logic [31:0]            r_addr_out;

  logic [INDEX_WIDTH-1:0] w_idx;
  logic [TAG_WIDTH-1:0]   w_tag;
  logic [BLOCK_WIDTH+2:0] w_bitoff;
  logic                   w_hit;
  logic [DATA_W-1:0]      w_hit_line;
  logic [31:0]            w_hit_word;

  logic [INDEX_WIDTH-1:0] w_fill_idx;
  logic [TAG_WIDTH-1:0]   w_fill_tag;
  logic                   w_free_found;
  logic [VW-1:0]          w_fill_way;
  logic [VW-1:0]          w_victim;

  logic                   w_hit_take;
  logic                   w_miss_take;
  logic                   w_fill;

  assign w_idx      = instrAddrIn[BLOCK_WIDTH+INDEX_WIDTH-1:BLOCK_WIDTH];
  assign w_tag      = instrAddrIn[31:BLOCK_WIDTH+INDEX_WIDTH];
  assign w_bitoff   = {instrAddrIn[BLOCK_WIDTH-1:0], 3'b000} & BITOFF_MASK;
  assign w_fill_idx = r_blk_addr[INDEX_WIDTH-1:0];
  assign w_fill_tag = r_blk_addr[BA_W-1:INDEX_WIDTH];

  // Tag compare across all ways of the addressed set.
  always_comb begin
    w_hit      = 1'b0;
    w_hit_line = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag)) begin
        w_hit      = 1'b1;
        w_hit_line = r_data[w_idx][w];
      end
    end
  end

  assign w_hit_word = w_hit_line[w_bitoff +: 32];

  // Scan downwards so the lowest-numbered invalid way wins.
  always_comb begin
    w_free_found = 1'b0;
    w_fill_way   = w_victim;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!r_valid[w_fill_idx][w]) begin
        w_free_found = 1'b1;
        w_fill_way   = VW'(w);
      end
    end
  end

  generate
    if (WAY_WIDTH > 0) begin : g_victim
      logic [VW-1:0] r_victim [SETS];

      // The pointer only advances when a valid line is actually displaced.
      always_ff @(posedge clkIn or posedge resetIn) begin
        if (resetIn) begin
          for (int s = 0; s < SETS; s++) r_victim[s] <= '0;
        end else if (flushIn) begin
          for (int s = 0; s < SETS; s++) r_victim[s] <= '0;
        end else if (w_fill && !w_free_found) begin
          r_victim[w_fill_idx] <= r_victim[w_fill_idx] + VW'(1);
        end
      end

      assign w_victim = r_victim[w_fill_idx];
    end else begin : g_direct
      assign w_victim = '0;
    end
  endgenerate

  // FSM state register.
  always_ff @(posedge clkIn or posedge resetIn) begin
    if (resetIn) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // FSM next state; a flush in IDLE suppresses the lookup for that cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_hit_take  = 1'b0;
    w_miss_take = 1'b0;
    w_fill      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (instrInValid && !flushIn) begin
          if (w_hit) begin
            w_hit_take = 1'b1;
          end else begin
            w_miss_take = 1'b1;
            w_state_nxt = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (memReqReady) w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (memDataValid) begin
          w_fill      = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Valid bits: a flush clears everything, which also covers a fill landing
  // in the same cycle. A poisoned fill still writes, but leaves the way invalid.
  always_ff @(posedge clkIn or posedge resetIn) begin
    if (resetIn) begin
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++) r_valid[s][w] <= 1'b0;
    end else if (flushIn) begin
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++) r_valid[s][w] <= 1'b0;
    end else if (w_fill) begin
      r_valid[w_fill_idx][w_fill_way] <= !r_poison;
    end
  end

  // Tag and data arrays carry no reset; they are qualified by the valid bits.
  always_ff @(posedge clkIn) begin
    if (w_fill) begin
      r_tag[w_fill_idx][w_fill_way]  <= w_fill_tag;
      r_data[w_fill_idx][w_fill_way] <= memDataIn;
    end
  end

  always_ff @(posedge clkIn or posedge resetIn) begin
    if (resetIn) begin
      r_blk_addr  <= '0;
      r_poison    <= 1'b0;
      r_out_valid <= 1'b0;
      r_instr     <= '0;
      r_addr_out  <= '0;
    end else begin
      r_out_valid <= w_hit_take;
      if (w_hit_take) begin
        r_instr    <= w_hit_word;
        r_addr_out <= instrAddrIn;
      end
      if (w_miss_take) r_blk_addr <= instrAddrIn[31:BLOCK_WIDTH];
      if (w_fill)
        r_poison <= 1'b0;
      else if (flushIn && (r_state != ST_IDLE))
        r_poison <= 1'b1;
    end
  end

  assign instrOutValid = r_out_valid;
  assign instrOut      = r_instr;
  assign instrAddrOut  = r_addr_out;
  assign memReqValid   = (r_state == ST_REQ);
  assign memReqAddr    = r_blk_addr;

endmodule

// File: tb/tb_icache_set_assoc.sv
// tb/tb_icache_set_assoc.sv - directed vector bench for icache_set_assoc

module tb_icache_set_assoc;

  logic         clkIn;
  logic         resetIn;
  logic         flushIn;
  logic         instrInValid;
  logic [31:0]  instrAddrIn;
  logic         instrOutValid;
  logic [31:0]  instrOut;
  logic [31:0]  instrAddrOut;
  logic         memReqValid;
  logic [27:0]  memReqAddr;
  logic         memReqReady;
  logic         memDataValid;
  logic [127:0] memDataIn;

  int n_vec = 0;
  int n_bad = 0;

  icache_set_assoc dut (
    .clkIn        (clkIn),
    .resetIn      (resetIn),
    .flushIn      (flushIn),
    .instrInValid (instrInValid),
    .instrAddrIn  (instrAddrIn),
    .instrOutValid(instrOutValid),
    .instrOut     (instrOut),
    .instrAddrOut (instrAddrOut),
    .memReqValid  (memReqValid),
    .memReqAddr   (memReqAddr),
    .memReqReady  (memReqReady),
    .memDataValid (memDataValid),
    .memDataIn    (memDataIn)
  );

  initial clkIn = 1'b0;
  always #5 clkIn = ~clkIn;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1);
  end

  typedef struct {
    logic [31:0] addr;
    logic        miss;
    logic [31:0] word;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Memory contents: block 0x100 holds the known words, every other word is
  // its address xor a fixed pattern.
  function automatic logic [31:0] word_of(input logic [31:0] a);
    if (a[31:4] == 28'h0000100) begin
      case (a[3:2])
        2'd0:    word_of = 32'hAAAA0000;
        2'd1:    word_of = 32'hBBBB0001;
        2'd2:    word_of = 32'hCCCC0002;
        default: word_of = 32'hDDDD0003;
      endcase
    end else begin
      word_of = a ^ 32'h5A5A0000;
    end
  endfunction

  function automatic logic [127:0] blk(input logic [31:0] a);
    logic [127:0] b;
    for (int i = 0; i < 4; i++) b[i*32 +: 32] = word_of({a[31:4], 4'h0} + 32'(i * 4));
    return b;
  endfunction

  // One fetch: a hit delivers after one edge; a miss is served with immediate
  // ready and one-cycle memory latency, then delivers after the re-lookup.
  task automatic fetch(input logic [31:0] a, input logic exp_miss, input logic [31:0] exp_word);
    logic saw;
    instrInValid = 1'b1;
    instrAddrIn  = a;
    @(posedge clkIn); #1;
    saw = memReqValid;
    if (saw) begin
      check("req_addr", 32'(memReqAddr), {4'h0, a[31:4]});
      memReqReady = 1'b1;
      @(posedge clkIn); #1;
      memReqReady = 1'b0;
      check("req_drop", 32'(memReqValid), 32'd0);
      memDataValid = 1'b1;
      memDataIn    = blk(a);
      @(posedge clkIn); #1;
      memDataValid = 1'b0;
      @(posedge clkIn); #1;
    end
    check("miss", 32'(saw), 32'(exp_miss));
    check("out_valid", 32'(instrOutValid), 32'd1);
    check("instr", instrOut, exp_word);
    check("instr_addr", instrAddrOut, a);
    instrInValid = 1'b0;
    @(posedge clkIn); #1;
    check("pulse_end", 32'(instrOutValid), 32'd0);
  endtask

  initial begin
    vecs[0]  = '{32'h00002000, 1'b1, 32'h5A5A2000};
    vecs[1]  = '{32'h00003000, 1'b1, 32'h5A5A3000};
    vecs[2]  = '{32'h00002000, 1'b0, 32'h5A5A2000};
    vecs[3]  = '{32'h00001000, 1'b1, 32'hAAAA0000};
    vecs[4]  = '{32'h00003000, 1'b0, 32'h5A5A3000};
    vecs[5]  = '{32'h00002000, 1'b1, 32'h5A5A2000};
    vecs[6]  = '{32'h0000100C, 1'b0, 32'hDDDD0003};
    vecs[7]  = '{32'h00003008, 1'b1, 32'h5A5A3008};
    vecs[8]  = '{32'h00001010, 1'b1, 32'h5A5A1010};
    vecs[9]  = '{32'h00001014, 1'b0, 32'h5A5A1014};
    vecs[10] = '{32'h00002004, 1'b0, 32'h5A5A2004};

    resetIn      = 1'b1;
    flushIn      = 1'b0;
    instrInValid = 1'b0;
    instrAddrIn  = '0;
    memReqReady  = 1'b0;
    memDataValid = 1'b0;
    memDataIn    = '0;
    #1;
    check("rst_out_valid", 32'(instrOutValid), 32'd0);
    check("rst_req_valid", 32'(memReqValid), 32'd0);
    check("rst_instr", instrOut, 32'd0);
    check("rst_req_addr", 32'(memReqAddr), 32'd0);
    @(posedge clkIn); @(posedge clkIn); #1;
    resetIn = 1'b0;

    // Cold miss with memory stalling the request for three cycles.
    instrInValid = 1'b1;
    instrAddrIn  = 32'h00001004;
    @(posedge clkIn); #1;
    check("cold_req", 32'(memReqValid), 32'd1);
    check("cold_req_addr", 32'(memReqAddr), 32'h00000100);
    for (int i = 0; i < 3; i++) begin
      @(posedge clkIn); #1;
      check("stall_req", 32'(memReqValid), 32'd1);
      check("stall_addr", 32'(memReqAddr), 32'h00000100);
    end
    memReqReady = 1'b1;
    @(posedge clkIn); #1;
    memReqReady = 1'b0;
    check("cold_req_drop", 32'(memReqValid), 32'd0);
    @(posedge clkIn); #1;
    memDataValid = 1'b1;
    memDataIn    = {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
    @(posedge clkIn); #1;
    memDataValid = 1'b0;
    check("cold_no_early_out", 32'(instrOutValid), 32'd0);
    @(posedge clkIn); #1;
    check("cold_out_valid", 32'(instrOutValid), 32'd1);
    check("cold_instr", instrOut, 32'hBBBB0001);
    check("cold_addr", instrAddrOut, 32'h00001004);
    instrInValid = 1'b0;
    @(posedge clkIn); #1;
    check("cold_pulse_end", 32'(instrOutValid), 32'd0);

    // Back-to-back hit stream across the block.
    instrInValid = 1'b1;
    instrAddrIn  = 32'h00001000;
    for (int i = 0; i < 4; i++) begin
      @(posedge clkIn); #1;
      check("stream_valid", 32'(instrOutValid), 32'd1);
      check("stream_instr", instrOut, word_of(32'h00001000 + 32'(i * 4)));
      check("stream_addr", instrAddrOut, 32'h00001000 + 32'(i * 4));
      check("stream_no_req", 32'(memReqValid), 32'd0);
      if (i < 3) instrAddrIn = 32'h00001000 + 32'(i * 4 + 4);
      else       instrInValid = 1'b0;
    end
    @(posedge clkIn); #1;
    check("stream_end", 32'(instrOutValid), 32'd0);

    // Replacement sequence in set 0 plus a second set.
    for (int v = 0; v < 11; v++) fetch(vecs[v].addr, vecs[v].miss, vecs[v].word);

    // Flush with a same-cycle lookup of a resident line: suppressed, then misses.
    flushIn      = 1'b1;
    instrInValid = 1'b1;
    instrAddrIn  = 32'h00001014;
    @(posedge clkIn); #1;
    flushIn = 1'b0;
    check("flush_no_out", 32'(instrOutValid), 32'd0);
    check("flush_no_req", 32'(memReqValid), 32'd0);
    fetch(32'h00001014, 1'b1, 32'h5A5A1014);
    fetch(32'h00002004, 1'b1, 32'h5A5A2004);

    // Flush during WAIT: the returned block is unusable and is re-requested.
    instrInValid = 1'b1;
    instrAddrIn  = 32'h00004000;
    @(posedge clkIn); #1;
    check("fw_req", 32'(memReqValid), 32'd1);
    memReqReady = 1'b1;
    @(posedge clkIn); #1;
    memReqReady = 1'b0;
    flushIn     = 1'b1;
    @(posedge clkIn); #1;
    flushIn      = 1'b0;
    memDataValid = 1'b1;
    memDataIn    = blk(32'h00004000);
    @(posedge clkIn); #1;
    memDataValid = 1'b0;
    @(posedge clkIn); #1;
    check("fw_no_out", 32'(instrOutValid), 32'd0);
    check("fw_rereq", 32'(memReqValid), 32'd1);
    check("fw_rereq_addr", 32'(memReqAddr), 32'h00000400);
    memReqReady = 1'b1;
    @(posedge clkIn); #1;
    memReqReady  = 1'b0;
    memDataValid = 1'b1;
    @(posedge clkIn); #1;
    memDataValid = 1'b0;
    @(posedge clkIn); #1;
    check("fw_out_valid", 32'(instrOutValid), 32'd1);
    check("fw_instr", instrOut, 32'h5A5A4000);
    instrInValid = 1'b0;
    @(posedge clkIn); #1;

    // Redirect: requester withdraws during REQ; refill still installs.
    instrInValid = 1'b1;
    instrAddrIn  = 32'h00006000;
    @(posedge clkIn); #1;
    instrInValid = 1'b0;
    memReqReady  = 1'b1;
    @(posedge clkIn); #1;
    memReqReady  = 1'b0;
    memDataValid = 1'b1;
    memDataIn    = blk(32'h00006000);
    @(posedge clkIn); #1;
    memDataValid = 1'b0;
    @(posedge clkIn); #1;
    check("redir_no_out", 32'(instrOutValid), 32'd0);
    check("redir_no_req", 32'(memReqValid), 32'd0);
    fetch(32'h00006000, 1'b0, 32'h5A5A6000);

    // Asynchronous reset while waiting for data.
    instrInValid = 1'b1;
    instrAddrIn  = 32'h00005000;
    @(posedge clkIn); #1;
    memReqReady = 1'b1;
    @(posedge clkIn); #1;
    memReqReady = 1'b0;
    @(posedge clkIn); #3;
    resetIn = 1'b1;
    #1;
    check("async_req_low", 32'(memReqValid), 32'd0);
    check("async_req_addr", 32'(memReqAddr), 32'd0);
    instrInValid = 1'b0;
    @(posedge clkIn); #1;
    resetIn      = 1'b0;
    memDataValid = 1'b1;
    memDataIn    = blk(32'h00005000);
    @(posedge clkIn); #1;
    memDataValid = 1'b0;
    check("late_data_no_out", 32'(instrOutValid), 32'd0);
    check("late_data_no_req", 32'(memReqValid), 32'd0);
    fetch(32'h00004000, 1'b1, 32'h5A5A4000);
    fetch(32'h00005000, 1'b1, 32'h5A5A5000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
